// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited fetch requests, in-order response
// queue of {instr, pc}, redirect flush with stale-response dropping.
// Ports: clk_i/rst_i (sync, active-high); redirect_i/redirect_pc_i;
// imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/imem_rdata_i (memory);
// instr_valid_o/instr_o/instr_pc_o/instr_pc4_o/instr_ready_i (to the CPU).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_pc4_o,
  input  logic        instr_ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic [31:0] ipc_q [DEPTH];
  logic [31:0] ipc_d [DEPTH];
  ptr_t        rptr_q, rptr_d;
  ptr_t        wptr_q, wptr_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic        grant;
  logic        rsp;
  logic        push;
  logic        pop;
  logic [CW:0] used;
  cnt_t        live;
  logic [31:0] rsp_pc;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  assign used = {1'b0, cnt_q} + {1'b0, outst_q};

  assign imem_req_o = !rst_i && !redirect_i
                      && (used < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_q;

  assign instr_valid_o = (cnt_q != '0);
  assign instr_o       = instr_valid_o ? instr_q[rptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? ipc_q[rptr_q] : '0;
  assign instr_pc4_o   = instr_pc_o + 32'd4;

  // Live (non-dropped) grants are always the most recent ones and are
  // consecutive words ending just below the fetch PC, so the oldest live
  // grant's address is recovered without storing in-flight addresses.
  assign live   = outst_q - drop_q;
  assign rsp_pc = pc_q - (32'(live) << 2);

  always_comb begin
    grant = imem_req_o && imem_gnt_i;
    rsp   = imem_rvalid_i && (outst_q != '0);
    push  = rsp && (drop_q == '0) && !redirect_i;
    pop   = instr_valid_o && instr_ready_i && !redirect_i;

    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    outst_d = outst_q + cnt_t'(grant) - cnt_t'(rsp);

    if (grant) begin
      pc_d = pc_q + 32'd4;
    end
    if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - cnt_t'(1);
    end
    if (push) begin
      instr_d[wptr_q] = imem_rdata_i;
      ipc_d[wptr_q]   = rsp_pc;
      wptr_d          = wptr_q + ptr_t'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + ptr_t'(1);
    end
    cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

    // No grant can coincide with a redirect, so outst_d here already
    // reflects this cycle's response; every remaining grant is stale.
    if (redirect_i) begin
      pc_d   = {redirect_pc_i[31:2], 2'b00};
      cnt_d  = '0;
      rptr_d = wptr_q;
      drop_d = outst_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    instr_q <= instr_d;
    ipc_q   <= ipc_d;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4: the instruction queue depth; a power of two, 2..16.
REQ-003 The block SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port redirect_i, input, 1 bit: a taken branch or jump from the CPU (branch & zero).
REQ-007 The block SHALL have port redirect_pc_i, input, 32 bits: the redirect target.
REQ-008 The block SHALL have port imem_req_o, output, 1 bit: fetch request to instruction memory.
REQ-009 The block SHALL have port imem_addr_o, output, 32 bits: the fetch byte address, word-aligned.
REQ-010 The block SHALL have port imem_gnt_i, input, 1 bit: memory accepts the request this cycle.
REQ-011 The block SHALL have port imem_rvalid_i, input, 1 bit: response data valid; responses return in order.
REQ-012 The block SHALL have port imem_rdata_i, input, 32 bits: the instruction word.
REQ-013 The block SHALL have port instr_valid_o, output, 1 bit: the queue head is valid.
REQ-014 The block SHALL have port instr_o, output, 32 bits: the head instruction.
REQ-015 The block SHALL have port instr_pc_o, output, 32 bits: the head instruction's address.
REQ-016 The block SHALL have port instr_pc4_o, output, 32 bits: instr_pc_o+4, modulo 2^32.
REQ-017 The block SHALL have port instr_ready_i, input, 1 bit: the CPU consumes the head this cycle.

Function
REQ-018 The block SHALL hold state: fetch PC, a DEPTH-entry FIFO of {instr, pc}, an outstanding counter, and a drop counter.
REQ-019 Credit: the block SHALL assert imem_req_o only when (FIFO occupancy + outstanding) < DEPTH, redirect_i=0 and rst_i=0.
REQ-020 imem_addr_o SHALL equal the fetch PC.
REQ-021 The fetch PC SHALL change only on a grant (req&gnt) or a redirect.
REQ-022 A grant SHALL advance the fetch PC by 4, wrapping 32'hFFFF_FFFC -> 0, and increment outstanding.
REQ-023 The block SHALL accept at most one grant per cycle.
REQ-024 Response with drop=0: the block SHALL push {imem_rdata_i, pc} into the FIFO, where pc is the address of the oldest outstanding grant, and decrement outstanding.
REQ-025 Response with drop>0: the block SHALL discard the data and decrement both drop and outstanding.
REQ-026 The block SHALL ignore imem_rvalid_i when outstanding=0 and leave all state unchanged.
REQ-027 Pop: valid&ready SHALL remove the head; push and pop in the same cycle are both performed.
REQ-028 Data pushed in cycle N SHALL be visible at the outputs no earlier than cycle N+1 (no bypass).
REQ-029 instr_valid_o SHALL be 1 exactly when the FIFO is non-empty.
REQ-030 Outputs SHALL be stable while instr_valid_o=1 and instr_ready_i=0.
REQ-031 Redirect in cycle N: the fetch PC SHALL become {redirect_pc_i[31:2],2'b00}.
REQ-032 Redirect in cycle N: the FIFO SHALL be emptied; any pop in cycle N is void.
REQ-033 Redirect in cycle N: drop SHALL become the outstanding count after cycle N's response, if any, is accounted for.
REQ-034 A response arriving in the redirect cycle SHALL be discarded.
REQ-035 After a redirect, imem_req_o SHALL assert in N+1 with the target address if credit allows.
REQ-036 Back-to-back redirects SHALL each apply; the last one wins, and drop accumulates correctly.
REQ-037 Full queue: imem_req_o SHALL be 0; no overflow or underflow under any input sequence.
REQ-038 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-039 While rst_i=1 at a clock edge, the block SHALL set fetch PC=RESET_PC, FIFO empty, outstanding=0, drop=0.
REQ-040 During reset, imem_req_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, instr_o=0, instr_pc_o=0 and instr_pc4_o=4.
REQ-041 The first request SHALL be issued in the first cycle with rst_i=0.
REQ-042 Reset mid-operation SHALL abandon in-flight responses; the memory is reset alongside.

Verification
REQ-043 Verification scenario: reset release with 1-cycle memory, gnt=1 and ready=1 -> addresses 0,4,8,... issued one per cycle; instr_valid_o first high 2 cycles after the first request; instr_pc_o sequence 0,4,8.
REQ-044 Verification scenario: ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, then imem_req_o=0; the FIFO holds PCs 0,4,8,C; the head is stable.
REQ-045 Verification scenario: 3 outstanding with 3-cycle latency, then redirect to 32'h0000_0103 -> next imem_addr_o=32'h100; the 3 old responses are dropped; first instr_pc_o=32'h100.
REQ-046 Verification scenario: redirect in the same cycle as rvalid and pop -> the response is discarded, the queue is empty next cycle and drop is correct.
REQ-047 Verification scenario: redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000; instr_pc4_o=0 for the first.
REQ-048 Verification scenario: spurious rvalid with outstanding=0 -> no push and no state change.
